// File: rtl/pixel_fifo_ctrl.sv
// Pointer/status controller making a reg_file a circular pixel FIFO; watermarks built only with PIXEL_FIFO_CTRL_WATERMARK_EN.
// Latency: wr_en is combinational with the push, pointers/level/flags update on the next clk edge.
// Backpressure: pushes are refused while full and pops while empty; refused requests latch sticky overflow/underflow.
module pixel_fifo_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic                push_ok;
  logic                pop_ok;
  logic [ADDR_WIDTH:0] level_nxt;

  // reset gating keeps reg_file untouched while the controller is held in reset
  assign push_ok = wr & ~full & ~flush & ~reset;
  assign pop_ok  = rd & ~empty & ~flush;
  assign wr_en   = push_ok;

  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else begin
      level_nxt = level + {{ADDR_WIDTH{1'b0}}, push_ok} - {{ADDR_WIDTH{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_addr    <= '0;
      r_addr    <= '0;
      level     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        w_addr <= '0;
        r_addr <= '0;
      end else begin
        if (push_ok) w_addr <= w_addr + 1'b1;
        if (pop_ok)  r_addr <= r_addr + 1'b1;
      end
      level     <= level_nxt;
      full      <= (level_nxt == DEPTH_L);
      empty     <= (level_nxt == '0);
      // a new error in the same cycle as clr_err stays set
      overflow  <= (wr & full & ~flush)  | (overflow  & ~clr_err);
      underflow <= (rd & empty & ~flush) | (underflow & ~clr_err);
    end
  end

`ifdef PIXEL_FIFO_CTRL_WATERMARK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      almost_full  <= 1'b0;
      almost_empty <= (AE_LEVEL >= 0);
    end else begin
      almost_full  <= (int'(level_nxt) >= AF_LEVEL);
      almost_empty <= (int'(level_nxt) <= AE_LEVEL);
    end
  end
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_fifo_ctrl.sv
// Bench for pixel_fifo_ctrl: directed vector table, hand sequences and a random run against a queue model.
module tb_pixel_fifo_ctrl;
  localparam int AW    = 2;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          reset, wr, rd, flush, clr_err;
  logic          wr_en;
  logic [AW-1:0] w_addr, r_addr;
  logic [AW:0]   level;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  always #5 clk = ~clk;

  pixel_fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr), .level(level),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference: pixel queue, pointer counters, sticky flags, plus a reg_file stand-in
  int q[$];
  int mem[DEPTH];
  int m_wp, m_rp, next_pix;
  bit m_ovf, m_unf;

  typedef struct {
    bit wr, rd, fl, clr;
    bit e_wren;
    int e_level;
    bit e_full, e_empty, e_ovf, e_unf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    bit e_af, e_ae;
`ifdef PIXEL_FIFO_CTRL_WATERMARK_EN
    e_af = (q.size() >= DEPTH - 1);
    e_ae = (q.size() <= 1);
`else
    e_af = 1'b0;
    e_ae = 1'b0;
`endif
    chk({tag, " level"}, 32'(level), q.size());
    chk({tag, " w_addr"}, 32'(w_addr), m_wp);
    chk({tag, " r_addr"}, 32'(r_addr), m_rp);
    chk({tag, " full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, " empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(m_unf));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(e_af));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(e_ae));
  endtask

  task automatic model_reset();
    q.delete();
    m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
  endtask

  // called just after a rising edge; returns the wr_en seen during the cycle
  task automatic step(input bit w, input bit r, input bit f, input bit c, output bit we_seen);
    bit push, pop;
    int d;
    logic [AW-1:0] wa;
    wr = w; rd = r; flush = f; clr_err = c;
    push = w && (q.size() < DEPTH) && !f;
    pop  = r && (q.size() > 0) && !f;
    #1;
    we_seen = wr_en;
    wa = w_addr;
    chk("wr_en", 32'(wr_en), 32'(push));
    if (pop) chk("pop data", mem[r_addr], q[0]);
    d = next_pix++;
    @(posedge clk);
    if (we_seen) mem[wa] = d;
    m_ovf = (m_ovf && !c) || (w && q.size() == DEPTH && !f);
    m_unf = (m_unf && !c) || (r && q.size() == 0 && !f);
    if (f) begin
      q.delete();
      m_wp = 0; m_rp = 0;
    end else begin
      if (pop)  begin void'(q.pop_front()); m_rp = (m_rp + 1) % DEPTH; end
      if (push) begin q.push_back(d);      m_wp = (m_wp + 1) % DEPTH; end
    end
    #1;
    check_state("step");
  endtask

  task automatic check_reset_values(input string tag);
    bit e_ae;
`ifdef PIXEL_FIFO_CTRL_WATERMARK_EN
    e_ae = 1'b1;
`else
    e_ae = 1'b0;
`endif
    chk({tag, " level"}, 32'(level), 0);
    chk({tag, " w_addr"}, 32'(w_addr), 0);
    chk({tag, " r_addr"}, 32'(r_addr), 0);
    chk({tag, " empty"}, 32'(empty), 1);
    chk({tag, " full"}, 32'(full), 0);
    chk({tag, " overflow"}, 32'(overflow), 0);
    chk({tag, " underflow"}, 32'(underflow), 0);
    chk({tag, " almost_full"}, 32'(almost_full), 0);
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(e_ae));
    chk({tag, " wr_en"}, 32'(wr_en), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[16];
    bit we;
    next_pix = 100;
    vecs[0]  = '{1,0,0,0, 1, 1, 0,0, 0,0};
    vecs[1]  = '{1,0,0,0, 1, 2, 0,0, 0,0};
    vecs[2]  = '{1,0,0,0, 1, 3, 0,0, 0,0};
    vecs[3]  = '{1,0,0,0, 1, 4, 1,0, 0,0};
    vecs[4]  = '{1,0,0,0, 0, 4, 1,0, 1,0};
    vecs[5]  = '{0,0,0,0, 0, 4, 1,0, 1,0};
    vecs[6]  = '{0,0,0,1, 0, 4, 1,0, 0,0};
    vecs[7]  = '{1,1,0,0, 0, 3, 0,0, 1,0};
    vecs[8]  = '{0,0,0,0, 0, 3, 0,0, 1,0};
    vecs[9]  = '{1,1,1,0, 0, 0, 0,1, 1,0};
    vecs[10] = '{1,1,0,0, 1, 1, 0,0, 1,1};
    vecs[11] = '{0,0,0,1, 0, 1, 0,0, 0,0};
    vecs[12] = '{0,1,0,0, 0, 0, 0,1, 0,0};
    vecs[13] = '{0,1,0,0, 0, 0, 0,1, 0,1};
    vecs[14] = '{0,1,0,1, 0, 0, 0,1, 0,1};
    vecs[15] = '{0,0,0,1, 0, 0, 0,1, 0,0};

    // wr held high during reset must not reach the reg_file
    reset = 1'b1; wr = 1'b1; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
    #2;
    check_reset_values("reset");
    wr = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].fl, vecs[i].clr, we);
      chk($sformatf("vec%0d wr_en", i), 32'(we), 32'(vecs[i].e_wren));
      chk($sformatf("vec%0d level", i), 32'(level), vecs[i].e_level);
      chk($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].e_empty));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].e_unf));
    end

    // steady push+pop at level 2 long enough for both pointers to wrap
    step(1, 0, 0, 0, we);
    step(1, 0, 0, 0, we);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0, we);
      chk("wrrd level", 32'(level), 2);
    end

    // asynchronous reset mid-burst at level 3
    step(1, 0, 0, 0, we);
    chk("pre-reset level", 32'(level), 3);
    wr = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async reset");
    wr = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("post reset");

    // random traffic: a filling phase then a draining phase
    for (int i = 0; i < 400; i++) begin
      bit w, r, f, c;
      w = ($urandom % 100) < ((i < 200) ? 70 : 40);
      r = ($urandom % 100) < ((i < 200) ? 40 : 70);
      f = ($urandom % 60) == 0;
      c = ($urandom % 15) == 0;
      step(w, r, f, c, we);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
